// File: rtl/hc4_pkg.sv
// Shared definitions for the register scan reader.
//   - Scan FSM state encoding (fixed values, visible in debug taps)
//   - clog2_min1: ceil(log2(n)) clamped to at least 1 bit, used for select
//     and bit-counter widths so single-entry configurations still get a port.
package hc4_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SELECT = 2'd1;
  localparam logic [1:0] ST_SHIFT  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SELECT = ST_SELECT,
    SHIFT  = ST_SHIFT,
    DONE   = ST_DONE
  } state_e;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_shifter.sv
// Parallel-in / serial-out shifter, MSB first.
// Ports:
//   clk       clock, rising edge
//   nReset    asynchronous active-low reset, clears the register
//   load_i    load pdata_i (has priority over shift_i)
//   shift_i   shift left by one, zero fill
//   pdata_i   parallel load value
//   sout_o    current MSB of the shift register (a register bit)
module piso_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] pdata_i,
  output logic             sout_o
);

  logic [WIDTH-1:0] shreg_q;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      shreg_q <= '0;
    end else if (load_i) begin
      shreg_q <= pdata_i;
    end else if (shift_i) begin
      shreg_q <= shreg_q << 1;
    end
  end

  assign sout_o = shreg_q[WIDTH-1];

endmodule

// File: rtl/register_scan_reader.sv
// Register scan reader: walks a select index over NREGS registers, captures
// each WIDTH-bit value from the external read mux and streams it out
// serially, MSB first, over a valid/ready bit handshake.
// Ports:
//   clk, nReset        clock / async active-low reset
//   nStart             active-low scan request, ignored while busy
//   sel                register select to external read mux
//   rdata              selected register value
//   sout, sout_valid   serial bit and its qualifier
//   sout_ready         consumer accepts bit when valid & ready at clk edge
//   sout_last          set while presenting bit 0 of the final register
//   busy               scan in progress
//   done               one-cycle pulse after the final bit is accepted
//
// state  | meaning
// IDLE   | waiting for nStart low
// SELECT | one cycle for the external mux to settle on sel
// SHIFT  | presenting bits of the captured register, waiting on handshakes
// DONE   | done pulse, returns to IDLE
module register_scan_reader
  import hc4_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREGS = 4,
  localparam int SELW  = clog2_min1(NREGS)
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             nStart,
  output logic [SELW-1:0]  sel,
  input  logic [WIDTH-1:0] rdata,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             sout_last,
  output logic             busy,
  output logic             done
);

  localparam int              BCW      = clog2_min1(WIDTH);
  localparam logic [SELW-1:0] LAST_IDX = SELW'(NREGS - 1);
  localparam logic [BCW-1:0]  TOP_BIT  = BCW'(WIDTH - 1);

  state_e          state_q;
  logic [SELW-1:0] idx_q;
  logic [BCW-1:0]  bitcnt_q;
  logic            valid_q;
  logic            last_q;
  logic            busy_q;
  logic            done_q;

  logic hs;
  logic at_last_reg;
  logic load;
  logic shift;

  assign hs          = valid_q & sout_ready;
  assign at_last_reg = (idx_q == LAST_IDX);
  // Capture happens on the SELECT exit edge; the shifter only moves on an
  // accepted bit that is not the register's final one.
  assign load        = (state_q == SELECT);
  assign shift       = (state_q == SHIFT) && hs && (bitcnt_q != '0);

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      bitcnt_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!nStart) begin
            state_q <= SELECT;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SELECT: begin
          state_q  <= SHIFT;
          bitcnt_q <= TOP_BIT;
          valid_q  <= 1'b1;
          // Single-bit registers present their last bit immediately.
          last_q   <= at_last_reg && (WIDTH == 1);
        end
        SHIFT: begin
          if (hs) begin
            if (bitcnt_q != '0) begin
              bitcnt_q <= bitcnt_q - BCW'(1);
              last_q   <= at_last_reg && (bitcnt_q == BCW'(1));
            end else begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              if (at_last_reg) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else begin
                idx_q   <= idx_q + SELW'(1);
                state_q <= SELECT;
              end
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  piso_shifter #(.WIDTH(WIDTH)) u_piso (
    .clk     (clk),
    .nReset  (nReset),
    .load_i  (load),
    .shift_i (shift),
    .pdata_i (rdata),
    .sout_o  (sout)
  );

  assign sel        = idx_q;
  assign sout_valid = valid_q;
  assign sout_last  = last_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_register_scan_reader.sv
// Directed bench for register_scan_reader: a 4x8 instance fed from a small
// register array through a bench-side mux, and a 1x8 instance fed 0x81.
module tb_register_scan_reader;

  logic clk = 1'b0;
  logic nReset;

  logic       nStart_a, sout_a, sout_valid_a, ready_a, sout_last_a, busy_a, done_a;
  logic [1:0] sel_a;
  logic [7:0] rdata_a;
  logic [7:0] regs [4];

  logic       nStart_b, sout_b, sout_valid_b, ready_b, sout_last_b, busy_b, done_b;
  logic [0:0] sel_b;
  logic [7:0] rdata_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always_comb rdata_a = regs[sel_a];

  register_scan_reader #(.WIDTH(8), .NREGS(4)) dut_a (
    .clk(clk), .nReset(nReset), .nStart(nStart_a), .sel(sel_a), .rdata(rdata_a),
    .sout(sout_a), .sout_valid(sout_valid_a), .sout_ready(ready_a),
    .sout_last(sout_last_a), .busy(busy_a), .done(done_a)
  );

  register_scan_reader #(.WIDTH(8), .NREGS(1)) dut_b (
    .clk(clk), .nReset(nReset), .nStart(nStart_b), .sel(sel_b), .rdata(rdata_b),
    .sout(sout_b), .sout_valid(sout_valid_b), .sout_ready(ready_b),
    .sout_last(sout_last_b), .busy(busy_b), .done(done_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One scan on instance A. Cycle 1 is the IDLE cycle in which nStart is low;
  // done is seen in the cycle numbered done_cyc.
  task automatic run_scan(input bit stall, input bit pulse_mid, input bit mod_rdata,
                          output logic [31:0] bits, output int nbits, output int done_cyc,
                          output int last_pos, output int nlast, output int unstable,
                          output bit timeout);
    int   cyc;
    bit   pend;
    logic p_sout, p_last;
    bits = '0; nbits = 0; done_cyc = 0; last_pos = 0; nlast = 0; unstable = 0;
    timeout = 1'b1; pend = 1'b0; p_sout = 1'b0; p_last = 1'b0;
    @(negedge clk);
    nStart_a = 1'b0;
    ready_a  = 1'b1;
    cyc = 1;
    for (int c = 0; c < 2000; c++) begin
      pend   = sout_valid_a && !ready_a;
      p_sout = sout_a;
      p_last = sout_last_a;
      if (sout_valid_a && ready_a) begin
        bits = {bits[30:0], sout_a};
        nbits++;
        if (sout_last_a) begin
          nlast++;
          last_pos = nbits;
        end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      nStart_a = !(pulse_mid && cyc == 12);
      if (mod_rdata && cyc == 4) begin
        regs[0] = 8'h11;
        regs[1] = 8'h77;
      end
      if (mod_rdata && cyc == 24) regs[2] = 8'h00;
      if (pend && (sout_a !== p_sout || sout_valid_a !== 1'b1 || sout_last_a !== p_last))
        unstable++;
      if (done_a) begin
        done_cyc = cyc;
        timeout  = 1'b0;
        break;
      end
      ready_a = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    nStart_a = 1'b1;
    ready_a  = 1'b1;
  endtask

  initial begin
    logic [31:0] bits;
    logic [15:0] bitsb;
    int nbits, done_cyc, last_pos, nlast, unstable, cyc, nb, d1, d2, lastb, selbad;
    int extra_done, extra_busy;
    bit timeout;
    logic idle_busy;

    nReset = 1'b0;
    nStart_a = 1'b1; ready_a = 1'b1;
    nStart_b = 1'b1; ready_b = 1'b1;
    rdata_b = 8'h81;
    regs[0] = 8'hA5; regs[1] = 8'h3C; regs[2] = 8'hFF; regs[3] = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_valid", 32'(sout_valid_a), 32'd0);
    check("rst_last", 32'(sout_last_a), 32'd0);
    check("rst_sel", 32'(sel_a), 32'd0);
    check("rst_sout", 32'(sout_a), 32'd0);
    nReset = 1'b1;
    @(negedge clk);

    // Reset in the middle of register 1's shift
    nStart_a = 1'b0;
    @(negedge clk);
    nStart_a = 1'b1;
    repeat (12) @(negedge clk);
    check("mid_sel_before_rst", 32'(sel_a), 32'd1);
    check("mid_busy_before_rst", 32'(busy_a), 32'd1);
    nReset = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    check("mid_rst_done", 32'(done_a), 32'd0);
    check("mid_rst_valid", 32'(sout_valid_a), 32'd0);
    check("mid_rst_last", 32'(sout_last_a), 32'd0);
    check("mid_rst_sel", 32'(sel_a), 32'd0);
    check("mid_rst_sout", 32'(sout_a), 32'd0);
    @(negedge clk);
    nReset = 1'b1;
    @(negedge clk);

    // Full scan, ready tied high
    run_scan(1'b0, 1'b0, 1'b0, bits, nbits, done_cyc, last_pos, nlast, unstable, timeout);
    check("full_timeout", 32'(timeout), 32'd0);
    check("full_bits", bits, 32'hA53CFF00);
    check("full_nbits", 32'(nbits), 32'd32);
    check("full_done_cyc", 32'(done_cyc), 32'd38);
    check("full_last_pos", 32'(last_pos), 32'd32);
    check("full_nlast", 32'(nlast), 32'd1);
    repeat (3) @(negedge clk);

    // Random back-pressure
    run_scan(1'b1, 1'b0, 1'b0, bits, nbits, done_cyc, last_pos, nlast, unstable, timeout);
    check("stall_timeout", 32'(timeout), 32'd0);
    check("stall_bits", bits, 32'hA53CFF00);
    check("stall_nbits", 32'(nbits), 32'd32);
    check("stall_unstable", 32'(unstable), 32'd0);
    check("stall_nlast", 32'(nlast), 32'd1);
    repeat (3) @(negedge clk);

    // nStart pulse during SHIFT is ignored
    run_scan(1'b0, 1'b1, 1'b0, bits, nbits, done_cyc, last_pos, nlast, unstable, timeout);
    check("pulse_timeout", 32'(timeout), 32'd0);
    check("pulse_bits", bits, 32'hA53CFF00);
    check("pulse_done_cyc", 32'(done_cyc), 32'd38);
    extra_done = 0;
    extra_busy = 0;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      if (done_a) extra_done++;
      if (busy_a) extra_busy++;
      @(posedge clk);
      @(negedge clk);
    end
    check("pulse_extra_done", 32'(extra_done), 32'd0);
    check("pulse_extra_busy", 32'(extra_busy), 32'd0);

    // rdata changes during SHIFT; reg1 changes before its own SELECT
    run_scan(1'b0, 1'b0, 1'b1, bits, nbits, done_cyc, last_pos, nlast, unstable, timeout);
    check("mod_timeout", 32'(timeout), 32'd0);
    check("mod_bits", bits, 32'hA577FF00);
    check("mod_nbits", 32'(nbits), 32'd32);
    repeat (3) @(negedge clk);

    // NREGS=1 with nStart held low: two back-to-back scans
    bitsb = '0; nb = 0; d1 = 0; d2 = 0; lastb = 0; selbad = 0; idle_busy = 1'bx;
    @(negedge clk);
    nStart_b = 1'b0;
    cyc = 1;
    for (int c = 0; c < 40; c++) begin
      if (sout_valid_b && ready_b) begin
        bitsb = {bitsb[14:0], sout_b};
        nb++;
        if (sout_last_b) lastb++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (sel_b !== 1'b0) selbad++;
      if (done_b) begin
        if (d1 == 0) d1 = cyc;
        else if (d2 == 0) d2 = cyc;
      end
      if (cyc == 12) idle_busy = busy_b;
      if (cyc == 22) nStart_b = 1'b1;
      if (cyc == 24) break;
    end
    check("one_bits", 32'(bitsb), 32'h8181);
    check("one_nbits", 32'(nb), 32'd16);
    check("one_done1", 32'(d1), 32'd11);
    check("one_done2", 32'(d2), 32'd22);
    check("one_idle_busy", 32'(idle_busy), 32'd0);
    check("one_nlast", 32'(lastb), 32'd2);
    check("one_sel", 32'(selbad), 32'd0);
    check("one_end_busy", 32'(busy_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
